// File: rtl/network_rx_agg.sv
// Aggregates NUM_PORTS show-ahead receive FIFOs into one 9-bit word stream.
// Round-robin packet selection, per-port enable, length truncation and stall timeout.
module network_rx_agg #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_ID_W = 2,
    parameter int TS_WIDTH  = 19,
    parameter int MAX_LEN   = 1522,
    parameter int LEN_W     = 11,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [NUM_PORTS*9-1:0] iv_data,
    input  logic [NUM_PORTS-1:0]   iv_data_empty,
    output logic [NUM_PORTS-1:0]   ov_data_rd,
    input  logic [NUM_PORTS-1:0]   iv_port_en,
    input  logic [TS_WIDTH-1:0]    iv_timer,
    output logic [8:0]             ov_data,
    output logic                   o_data_wr,
    output logic [TS_WIDTH-1:0]    ov_rec_ts,
    output logic [PORT_ID_W-1:0]   ov_src_port,
    output logic                   o_pkt_valid_pulse,
    output logic                   o_trunc_pulse,
    output logic                   o_timeout_pulse,
    output logic [15:0]            ov_drop_cnt,
    output logic [1:0]             fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

    localparam logic [LEN_W-1:0]     LAST_IDX = LEN_W'(MAX_LEN - 1);
    localparam logic [7:0]           TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [PORT_ID_W-1:0] TOP_PORT = PORT_ID_W'(NUM_PORTS - 1);

    state_t               state, state_n;
    logic [PORT_ID_W-1:0] rr_ptr, rr_n, sel, sel_n, pick, port_mux, sel_inc;
    logic [LEN_W-1:0]     cnt, cnt_n;
    logic [7:0]           stall, stall_n;
    logic                 gap, gap_n, found, pop;
    logic [8:0]           words [NUM_PORTS];
    logic [8:0]           cur_word, data_n;
    logic                 cur_empty, wr_n, valid_n, trunc_n, to_n;
    logic [TS_WIDTH-1:0]  ts_n;
    logic [PORT_ID_W-1:0] src_n;
    logic [15:0]          drop_n;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_words
        assign words[k] = iv_data[9*k +: 9];
    end

    // Downward scan so the last hit is the nearest non-empty port at or above rr_ptr.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (!iv_data_empty[PORT_ID_W'((int'(rr_ptr) + i) % NUM_PORTS)]) begin
                pick  = PORT_ID_W'((int'(rr_ptr) + i) % NUM_PORTS);
                found = 1'b1;
            end
        end
    end

    assign port_mux  = (state == IDLE) ? pick : sel;
    assign cur_word  = words[port_mux];
    assign cur_empty = iv_data_empty[port_mux];
    assign sel_inc   = (sel == TOP_PORT) ? '0 : sel + 1'b1;
    assign fsm_state = state;

    // Pop handshake: ov_data_rd[k] consumes the word currently shown on port k
    // at this clock edge; it is only raised while that port is non-empty.
    assign ov_data_rd = (pop && reset_n) ? (NUM_PORTS'(1) << port_mux) : '0;

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        stall_n = stall;
        gap_n   = gap;
        pop     = 1'b0;
        data_n  = ov_data;
        wr_n    = 1'b0;
        valid_n = 1'b0;
        trunc_n = 1'b0;
        to_n    = 1'b0;
        ts_n    = ov_rec_ts;
        src_n   = ov_src_port;
        drop_n  = ov_drop_cnt;
        case (state)
            IDLE: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else if (found) begin
                    pop = 1'b1;
                    if (cur_word[8]) begin
                        sel_n   = pick;
                        cnt_n   = LEN_W'(1);
                        stall_n = '0;
                        if (iv_port_en[pick]) begin
                            state_n = FWD;
                            data_n  = cur_word;
                            wr_n    = 1'b1;
                            ts_n    = iv_timer;
                            src_n   = pick;
                        end else begin
                            state_n = DROP;
                            if (ov_drop_cnt != 16'hFFFF) drop_n = ov_drop_cnt + 16'd1;
                        end
                    end
                end
            end
            FWD: begin
                if (!cur_empty) begin
                    pop     = 1'b1;
                    stall_n = '0;
                    cnt_n   = cnt + 1'b1;
                    data_n  = cur_word;
                    wr_n    = 1'b1;
                    if (cur_word[8]) begin
                        valid_n = 1'b1;
                        state_n = IDLE;
                        rr_n    = sel_inc;
                        gap_n   = 1'b1;
                    end else if (cnt == LAST_IDX) begin
                        data_n[8] = 1'b1;
                        trunc_n   = 1'b1;
                        state_n   = DROP;
                    end
                end else if (stall == TO_LAST) begin
                    data_n  = 9'h100;
                    wr_n    = 1'b1;
                    to_n    = 1'b1;
                    state_n = IDLE;
                    rr_n    = sel_inc;
                    gap_n   = 1'b1;
                end else begin
                    stall_n = stall + 8'd1;
                end
            end
            DROP: begin
                if (!cur_empty) begin
                    pop     = 1'b1;
                    stall_n = '0;
                    if (cur_word[8]) begin
                        state_n = IDLE;
                        rr_n    = sel_inc;
                        gap_n   = 1'b1;
                    end
                end else if (stall == TO_LAST) begin
                    state_n = IDLE;
                    rr_n    = sel_inc;
                    gap_n   = 1'b1;
                end else begin
                    stall_n = stall + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            sel               <= '0;
            cnt               <= '0;
            stall             <= '0;
            gap               <= 1'b0;
            ov_data           <= '0;
            o_data_wr         <= 1'b0;
            ov_rec_ts         <= '0;
            ov_src_port       <= '0;
            o_pkt_valid_pulse <= 1'b0;
            o_trunc_pulse     <= 1'b0;
            o_timeout_pulse   <= 1'b0;
            ov_drop_cnt       <= '0;
        end else begin
            state             <= state_n;
            rr_ptr            <= rr_n;
            sel               <= sel_n;
            cnt               <= cnt_n;
            stall             <= stall_n;
            gap               <= gap_n;
            ov_data           <= data_n;
            o_data_wr         <= wr_n;
            ov_rec_ts         <= ts_n;
            ov_src_port       <= src_n;
            o_pkt_valid_pulse <= valid_n;
            o_trunc_pulse     <= trunc_n;
            o_timeout_pulse   <= to_n;
            ov_drop_cnt       <= drop_n;
        end
    end
endmodule

// File: tb/tb_network_rx_agg.sv
// Bench for network_rx_agg: queue-modelled show-ahead FIFOs feed the DUT and an
// expected-output queue is checked word by word against the aggregated stream.
module tb_network_rx_agg;
    localparam int NP   = 4;
    localparam int TSW  = 19;
    localparam int MAXL = 1522;
    localparam int TO   = 255;
    localparam int EW   = 3 + 2 + TSW + 9;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [NP*9-1:0] iv_data = '0;
    logic [NP-1:0]   iv_data_empty = '1;
    logic [NP-1:0]   ov_data_rd;
    logic [NP-1:0]   iv_port_en = '1;
    logic [TSW-1:0]  iv_timer = '0;
    logic [8:0]      ov_data;
    logic            o_data_wr;
    logic [TSW-1:0]  ov_rec_ts;
    logic [1:0]      ov_src_port;
    logic            o_pkt_valid_pulse, o_trunc_pulse, o_timeout_pulse;
    logic [15:0]     ov_drop_cnt;
    logic [1:0]      fsm_state;

    network_rx_agg dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .iv_data(iv_data), .iv_data_empty(iv_data_empty),
        .ov_data_rd(ov_data_rd), .iv_port_en(iv_port_en), .iv_timer(iv_timer), .ov_data(ov_data),
        .o_data_wr(o_data_wr), .ov_rec_ts(ov_rec_ts), .ov_src_port(ov_src_port),
        .o_pkt_valid_pulse(o_pkt_valid_pulse), .o_trunc_pulse(o_trunc_pulse),
        .o_timeout_pulse(o_timeout_pulse), .ov_drop_cnt(ov_drop_cnt), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    logic [8:0]    fifo_q [NP][$];
    logic [EW-1:0] exp_q[$];
    int            valid_cyc_q[$];
    int            head_cyc_q[$];
    int            pop_cnt [NP];
    int            cyc, n_vec, n_err, exp_drop, trunc_cnt, last_data_cyc, to_gap;

    function automatic bit fifos_busy();
        for (int k = 0; k < NP; k++) if (fifo_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: FIFO model pops on the edge, scoreboard checks on the falling edge.
    task automatic tick();
        logic [NP-1:0] rd_s;
        logic [EW-1:0] got, exp;
        @(posedge clk_sys);
        rd_s = ov_data_rd;
        cyc++;
        #1;
        if (rd_s != '0) begin
            n_vec++;
            if ($countones(rd_s) > 1) begin
                n_err++;
                $display("FAIL rd_onehot: got %b required at most one bit", rd_s);
            end
        end
        for (int k = 0; k < NP; k++) begin
            if (rd_s[k]) begin
                n_vec++;
                if (fifo_q[k].size() == 0) begin
                    n_err++;
                    $display("FAIL pop_empty: port %0d popped while empty", k);
                end else begin
                    void'(fifo_q[k].pop_front());
                    pop_cnt[k]++;
                end
            end
        end
        for (int k = 0; k < NP; k++) begin
            iv_data_empty[k]  = (fifo_q[k].size() == 0);
            iv_data[k*9 +: 9] = (fifo_q[k].size() == 0) ? 9'h000 : fifo_q[k][0];
        end
        @(negedge clk_sys);
        if (reset_n) begin
            if (o_data_wr) begin
                got = {o_pkt_valid_pulse, o_trunc_pulse, o_timeout_pulse, ov_src_port, ov_rec_ts, ov_data};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got %h required no output", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL out_word: got %h required %h", got, exp);
                    end
                end
                if (o_pkt_valid_pulse) valid_cyc_q.push_back(cyc);
                if (o_trunc_pulse) trunc_cnt++;
                if (o_timeout_pulse) to_gap = cyc - last_data_cyc;
                else last_data_cyc = cyc;
                if (ov_data[8] && !o_pkt_valid_pulse && !o_trunc_pulse && !o_timeout_pulse)
                    head_cyc_q.push_back(cyc);
            end else if ({o_pkt_valid_pulse, o_trunc_pulse, o_timeout_pulse} !== 3'b000) begin
                n_vec++;
                n_err++;
                $display("FAIL pulse_without_wr: got %b required 000",
                         {o_pkt_valid_pulse, o_trunc_pulse, o_timeout_pulse});
            end
        end
    endtask

    // driver tasks
    task automatic push_pkt(input int port, input int len, input bit has_tail, input bit fwd,
                            input logic [TSW-1:0] ts);
        logic [8:0] w;
        logic       vp, tp;
        for (int i = 0; i < len; i++) begin
            w = {1'b0, 8'($urandom_range(0, 255))};
            if (i == 0 || (has_tail && i == len - 1)) w[8] = 1'b1;
            fifo_q[port].push_back(w);
            if (fwd && i < MAXL) begin
                vp = has_tail && (i == len - 1);
                tp = (i == MAXL - 1) && !vp;
                if (tp) w[8] = 1'b1;
                exp_q.push_back({vp, tp, 1'b0, 2'(port), ts, w});
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifos_busy() || fsm_state != 2'd0) && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), n);
        end
        repeat (3) tick();
    endtask

    task automatic clear_marks();
        valid_cyc_q.delete();
        head_cyc_q.delete();
        trunc_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        n_vec++;
        if ({ov_data, o_data_wr, ov_data_rd, ov_rec_ts, ov_src_port, o_pkt_valid_pulse,
             o_trunc_pulse, o_timeout_pulse, ov_drop_cnt, fsm_state} !== '0) begin
            n_err++;
            $display("FAIL %s: data=%h wr=%b rd=%b ts=%h src=%h pulses=%b drop=%h state=%h required all 0",
                     tag, ov_data, o_data_wr, ov_data_rd, ov_rec_ts, ov_src_port,
                     {o_pkt_valid_pulse, o_trunc_pulse, o_timeout_pulse}, ov_drop_cnt, fsm_state);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        fifo_q[1].push_back(9'h055);
        repeat (2) tick();
        check_outputs_zero("reset_outputs");
        reset_n = 1'b1;
        wait_drain(50);
        n_vec++;
        if (pop_cnt[1] !== 1) begin
            n_err++;
            $display("FAIL desync_discard: got %0d pops required 1", pop_cnt[1]);
        end
    endtask

    task automatic test_round_robin();
        clear_marks();
        iv_timer = 100;
        push_pkt(0, 64, 1'b1, 1'b1, 100);
        push_pkt(2, 64, 1'b1, 1'b1, 200);
        repeat (10) tick();
        iv_timer = 200;
        wait_drain(400);
        n_vec++;
        if (valid_cyc_q.size() != 2 || head_cyc_q.size() != 2) begin
            n_err++;
            $display("FAIL rr_pkt_count: got %0d valid %0d heads required 2 2",
                     valid_cyc_q.size(), head_cyc_q.size());
        end else if (head_cyc_q[1] - valid_cyc_q[0] != 2) begin
            n_err++;
            $display("FAIL rr_bubble: got spacing %0d required 2", head_cyc_q[1] - valid_cyc_q[0]);
        end
    endtask

    task automatic test_disabled_port();
        int p0 = pop_cnt[0];
        iv_port_en = 4'b1110;
        push_pkt(0, 60, 1'b1, 1'b0, 0);
        repeat (5) tick();
        iv_port_en = 4'b1111;
        exp_drop++;
        wait_drain(300);
        n_vec++;
        if (pop_cnt[0] - p0 != 60) begin
            n_err++;
            $display("FAIL drop_pops: got %0d required 60", pop_cnt[0] - p0);
        end
        n_vec++;
        if (ov_drop_cnt !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d required %0d", ov_drop_cnt, exp_drop);
        end
    endtask

    task automatic test_en_change();
        clear_marks();
        iv_timer = 321;
        push_pkt(1, 30, 1'b1, 1'b1, 321);
        repeat (8) tick();
        iv_port_en = 4'b1101;
        wait_drain(200);
        iv_port_en = 4'b1111;
        n_vec++;
        if (valid_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL en_change_valid: got %0d required 1", valid_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_marks();
        iv_timer = 77;
        push_pkt(1, 16, 1'b1, 1'b1, 77);
        push_pkt(1, 2, 1'b1, 1'b1, 77);
        push_pkt(1, 5, 1'b1, 1'b1, 77);
        wait_drain(200);
        n_vec++;
        if (valid_cyc_q.size() != 3 || head_cyc_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d valid %0d heads required 3 3",
                     valid_cyc_q.size(), head_cyc_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (head_cyc_q[i+1] - valid_cyc_q[i] != 2) begin
                    n_err++;
                    $display("FAIL b2b_bubble: got spacing %0d required 2", head_cyc_q[i+1] - valid_cyc_q[i]);
                end
            end
        end
    endtask

    task automatic test_max_len_exact();
        int p2 = pop_cnt[2];
        clear_marks();
        iv_timer = 900;
        push_pkt(2, MAXL, 1'b1, 1'b1, 900);
        wait_drain(2000);
        n_vec++;
        if (pop_cnt[2] - p2 != MAXL || valid_cyc_q.size() != 1 || trunc_cnt != 0) begin
            n_err++;
            $display("FAIL max_len_exact: got pops %0d valid %0d trunc %0d required %0d 1 0",
                     pop_cnt[2] - p2, valid_cyc_q.size(), trunc_cnt, MAXL);
        end
    endtask

    task automatic test_truncation();
        int p3 = pop_cnt[3];
        clear_marks();
        iv_timer = 1000;
        push_pkt(3, 1600, 1'b1, 1'b1, 1000);
        wait_drain(2000);
        n_vec++;
        if (pop_cnt[3] - p3 != 1600 || trunc_cnt != 1 || valid_cyc_q.size() != 0) begin
            n_err++;
            $display("FAIL trunc_counts: got pops %0d trunc %0d valid %0d required 1600 1 0",
                     pop_cnt[3] - p3, trunc_cnt, valid_cyc_q.size());
        end
        n_vec++;
        if (ov_drop_cnt !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL trunc_drop_cnt: got %0d required %0d", ov_drop_cnt, exp_drop);
        end
    endtask

    task automatic test_timeout();
        int p1 = pop_cnt[1];
        clear_marks();
        to_gap   = -1;
        iv_timer = 4000;
        push_pkt(1, 20, 1'b0, 1'b1, 4000);
        exp_q.push_back({3'b001, 2'd1, TSW'(4000), 9'h100});
        wait_drain(600);
        n_vec++;
        if (to_gap != TO) begin
            n_err++;
            $display("FAIL timeout_gap: got %0d cycles required %0d", to_gap, TO);
        end
        repeat (45) tick();
        for (int i = 0; i < 10; i++) fifo_q[1].push_back({1'b0, 8'($urandom_range(0, 255))});
        wait_drain(100);
        n_vec++;
        if (pop_cnt[1] - p1 != 30) begin
            n_err++;
            $display("FAIL timeout_residual: got %0d pops required 30", pop_cnt[1] - p1);
        end
        push_pkt(1, 6, 1'b1, 1'b1, 4000);
        wait_drain(100);
        n_vec++;
        if (valid_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL timeout_recover: got %0d valid required 1", valid_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int p2 = pop_cnt[2];
        clear_marks();
        iv_timer = 555;
        push_pkt(2, 101, 1'b0, 1'b1, 555);
        repeat (20) tick();
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("reset_mid_async");
        exp_q.delete();
        exp_drop = 0;
        repeat (2) tick();
        check_outputs_zero("reset_mid_held");
        reset_n  = 1'b1;
        iv_timer = 600;
        push_pkt(0, 8, 1'b1, 1'b1, 600);
        wait_drain(300);
        n_vec++;
        if (pop_cnt[2] - p2 != 101 || valid_cyc_q.size() != 1 || ov_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_recover: got pops %0d valid %0d drop %0d required 101 1 0",
                     pop_cnt[2] - p2, valid_cyc_q.size(), ov_drop_cnt);
        end
    endtask

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; exp_drop = 0; trunc_cnt = 0;
        last_data_cyc = 0; to_gap = -1;
        for (int k = 0; k < NP; k++) pop_cnt[k] = 0;
        test_reset();
        test_round_robin();
        test_disabled_port();
        test_en_change();
        test_back_to_back();
        test_max_len_exact();
        test_truncation();
        test_timeout();
        test_reset_mid();
        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/network_rx_agg.md
NETWORK_RX_AGG -- requirements
Module: network_rx_agg

Interface
REQ-001 Parameter NUM_PORTS, default 4, sets the number of receive FIFO read-side channels; legal range 2..8.
REQ-002 Parameter PORT_ID_W, default 2, sets the width of the source-port index; it SHALL satisfy 2^PORT_ID_W >= NUM_PORTS.
REQ-003 Parameter TS_WIDTH, default 19, sets the width of the receive timestamp.
REQ-004 Parameter MAX_LEN, default 1522, sets the maximum forwarded bytes per packet; LEN_W, default 11, sets the byte-counter width.
REQ-005 Parameter TIMEOUT, default 255, sets the empty-stall cycles allowed mid-packet; the stall counter SHALL be 8 bits wide.
REQ-006 Port clk_sys, input, 1: the single clock.
REQ-007 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Port iv_data, input, NUM_PORTS*9: per-port show-ahead FIFO word; port k uses [9k+8:9k]; bit8 is the head/tail marker.
REQ-009 Port iv_data_empty, input, NUM_PORTS: per-port FIFO empty flag.
REQ-010 Port ov_data_rd, output, NUM_PORTS: per-port pop strobe; at most one bit is set per cycle.
REQ-011 Port iv_port_en, input, NUM_PORTS: per-port receive enable; it is sampled when a packet head is popped.
REQ-012 Port iv_timer, input, TS_WIDTH: free-running timestamp.
REQ-013 Ports ov_data (output, 9), o_data_wr (output, 1), ov_rec_ts (output, TS_WIDTH) and ov_src_port (output, PORT_ID_W) form the aggregated output stream.
REQ-014 Ports o_pkt_valid_pulse, o_trunc_pulse and o_timeout_pulse are outputs, 1 bit each: single-cycle event pulses.
REQ-015 Port ov_drop_cnt, output, 16: saturating count of dropped packets.

Function
REQ-016 Packet format: the first word has bit8=1; the tail is the next word with bit8=1; minimum packet length is 2 words.
REQ-017 States: IDLE, FWD and DROP; the state register SHALL take exactly one of these values at all times.
REQ-018 IDLE, port selection: the selected port is the first non-empty port found searching upward from rr_ptr, with wrap-around.
REQ-019 IDLE, head word: if the selected word has bit8=1, the block pops it, latches sel and samples iv_timer, then:
- goes to FWD if iv_port_en[sel]=1;
- otherwise goes to DROP and increments ov_drop_cnt.
REQ-020 IDLE, non-head word: if the selected word has bit8=0 (desync), the block pops and discards it, stays in IDLE and leaves rr_ptr unchanged.
REQ-021 FWD: each cycle the port is non-empty, the block pops one word; ov_data equals that word and o_data_wr=1 on the following cycle (latency 1).
REQ-022 The head word is output with bit8=1; ov_rec_ts and ov_src_port update in the head output cycle and hold until the next head output.
REQ-023 FWD normal end: on popping the tail, the block outputs it, pulses o_pkt_valid_pulse in the tail output cycle, sets rr_ptr=(sel+1) mod NUM_PORTS, and goes to IDLE.
REQ-024 FWD truncation: when the MAX_LEN-th word is popped and is not a tail, the block outputs it with bit8 forced to 1, pulses o_trunc_pulse with that word, and goes to DROP (ov_drop_cnt is not incremented).
REQ-025 FWD stall: while the port is empty, no pop occurs and o_data_wr=0; the stall counter increments and clears on any pop.
REQ-026 FWD timeout: when the stall counter reaches TIMEOUT, the block emits 9'h100 with o_data_wr=1, pulses o_timeout_pulse in the same cycle, advances rr_ptr, and goes to IDLE.
REQ-027 DROP: the block pops whenever the port is non-empty, without output, until the tail is popped; it then advances rr_ptr and goes to IDLE. A timeout in DROP returns to IDLE silently.
REQ-028 iv_port_en changes during a packet SHALL NOT affect that packet.
REQ-029 The minimum gap is one IDLE cycle between a tail pop and the next head pop.
REQ-030 ov_drop_cnt saturates at 16'hFFFF; the byte counter SHALL never wrap because MAX_LEN < 2^LEN_W.

Reset
REQ-031 When reset_n=0, the block SHALL immediately:
- set state to IDLE;
- clear rr_ptr, sel, the byte counter and the stall counter;
- drive all outputs (ov_data, o_data_wr, ov_data_rd, ov_rec_ts, ov_src_port, all pulses, ov_drop_cnt) to 0.
REQ-032 A reset mid-packet SHALL abandon the packet with no tail emitted; residual FIFO words are later removed by REQ-020.

Verification
REQ-033 Round-robin scenario:
- Stimulus: ports 0 and 2 each hold a 64-byte packet, all enabled, iv_timer=100 at the port-0 head pop.
- Response: port-0 packet first with ov_rec_ts=100 and ov_src_port=0, then port-2 packet; two o_pkt_valid_pulse; one bubble between packets.
REQ-034 Disabled-port scenario:
- Stimulus: iv_port_en=4'b1110 and a 60-byte packet on port 0.
- Response: 60 pops, o_data_wr never asserted, ov_drop_cnt=1.
REQ-035 Truncation scenario:
- Stimulus: MAX_LEN=1522 and a 1600-byte packet.
- Response: exactly 1522 words output, the last with bit8=1; o_trunc_pulse once; 78 words discarded; ov_drop_cnt unchanged.
REQ-036 Timeout scenario:
- Stimulus: port goes empty after 20 words for 300 cycles.
- Response: at stall cycle 255, 9'h100 is output with o_timeout_pulse; the following residual words are discarded in IDLE.
REQ-037 Reset scenario:
- Stimulus: reset_n pulsed low mid-FWD.
- Response: all outputs 0 during reset; after release, the first head found on any port is forwarded correctly.
